// File: rtl/dot_stencil_pipe.sv
// Pipelined FP32 dot-product engine: NT lane products, registered adder tree,
// optional accumulation of beats into one group result, valid/ready handshake.
module dot_stencil_pipe #(
    parameter int NT     = 3,
    parameter int BW     = 32,
    parameter bit ACC_EN = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [BW*NT-1:0] io_in_data,
    input  logic [BW*NT-1:0] io_in_weight,
    input  logic             io_in_last,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [BW-1:0]    io_out_data
);
    localparam int L = (NT > 1) ? $clog2(NT) : 0;

    // Denormal operands read as signed zero; underflowing results flush to signed zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic              s, g, st, a_z, b_z, a_i, b_i, a_n, b_n;
        logic [47:0]       p;
        logic [24:0]       m;
        logic signed [9:0] e;
        s   = a[31] ^ b[31];
        a_z = (a[30:23] == 8'd0);
        b_z = (b[30:23] == 8'd0);
        a_i = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_i = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_n = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_n = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        p   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e   = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (p[47]) begin
            m  = {1'b0, p[47:24]};
            g  = p[23];
            st = |p[22:0];
            e  = e + 10'sd1;
        end else begin
            m  = {1'b0, p[46:23]};
            g  = p[22];
            st = |p[21:0];
        end
        if (g && (st || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 10'sd1;
        end
        if (a_n || b_n || (a_i && b_z) || (b_i && a_z)) fp_mul = 32'h7FC00000;
        else if (a_i || b_i)                            fp_mul = {s, 8'hFF, 23'd0};
        else if (a_z || b_z || (e <= 10'sd0))           fp_mul = {s, 31'd0};
        else if (e >= 10'sd255)                         fp_mul = {s, 8'hFF, 23'd0};
        else                                            fp_mul = {s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       x, y;
        logic [7:0]        d;
        logic [26:0]       mx, my, ys;
        logic [27:0]       r;
        logic [24:0]       m;
        logic              g, st, r_z, a_z, b_z, a_i, b_i, a_n, b_n;
        logic signed [9:0] e;
        a_z = (a[30:23] == 8'd0);
        b_z = (b[30:23] == 8'd0);
        a_i = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_i = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_n = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_n = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (b[30:0] > a[30:0]) begin
            x = b;
            y = a;
        end else begin
            x = a;
            y = b;
        end
        d  = x[30:23] - y[30:23];
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, y[22:0], 3'b000};
        if (d >= 8'd27) begin
            ys = 27'd1;
        end else begin
            ys = my >> d;
            if ((my & ((27'd1 << d) - 27'd1)) != 27'd0) ys[0] = 1'b1;
        end
        if (x[31] == y[31]) r = {1'b0, mx} + {1'b0, ys};
        else                r = {1'b0, mx} - {1'b0, ys};
        r_z = (r == 28'd0);
        e   = $signed({2'b00, x[30:23]});
        if (r[27]) begin
            r = {1'b0, r[27:2], r[1] | r[0]};
            e = e + 10'sd1;
        end else begin
            // Massive cancellation only happens when d <= 1, so no sticky bits are lost here.
            for (int i = 0; i < 26; i++) begin
                if (!r[26]) begin
                    r = r << 1;
                    e = e - 10'sd1;
                end else begin
                    r = r;
                end
            end
        end
        m  = {1'b0, r[26:3]};
        g  = r[2];
        st = |r[1:0];
        if (g && (st || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 10'sd1;
        end
        if (a_n || b_n || (a_i && b_i && (a[31] != b[31]))) fp_add = 32'h7FC00000;
        else if (a_i)                                       fp_add = a;
        else if (b_i)                                       fp_add = b;
        else if (a_z && b_z)                                fp_add = {a[31] & b[31], 31'd0};
        else if (a_z)                                       fp_add = b;
        else if (b_z)                                       fp_add = a;
        else if (r_z)                                       fp_add = 32'd0;
        else if (e >= 10'sd255)                             fp_add = {x[31], 8'hFF, 23'd0};
        else if (e <= 10'sd0)                               fp_add = {x[31], 31'd0};
        else                                                fp_add = {x[31], e[7:0], m[22:0]};
    endfunction

    logic [31:0] lvl_q [0:L][0:NT-1];
    logic [31:0] lvl_d [0:L][0:NT-1];
    logic [31:0] pad_s [0:2*NT-1];
    logic [L:0]  vld_q, vld_d, last_q, last_d;
    logic [31:0] acc_q, acc_d, out_data_q, out_data_d, sum_s;
    logic        out_valid_q, out_valid_d, stall_s;

    assign io_in_ready  = ~stall_s;
    assign io_out_valid = out_valid_q;
    assign io_out_data  = out_data_q;

    // Next-state for product stage, adder tree levels, tags, accumulator and output.
    always_comb begin
        stall_s     = out_valid_q & ~io_out_ready;
        lvl_d       = lvl_q;
        vld_d       = vld_q;
        last_d      = last_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        sum_s       = fp_add(acc_q, lvl_q[L][0]);
        for (int i = 0; i < 2*NT; i++) pad_s[i] = 32'd0;
        if (!stall_s) begin
            vld_d[0]  = io_in_valid;
            last_d[0] = io_in_last;
            for (int i = 0; i < NT; i++) begin
                if (io_in_valid) lvl_d[0][i] = fp_mul(io_in_data[BW*i +: BW], io_in_weight[BW*i +: BW]);
                else             lvl_d[0][i] = lvl_q[0][i];
            end
            // Lanes past the live count are zero, so they double as the +0.0 padding.
            for (int k = 1; k <= L; k++) begin
                for (int i = 0; i < 2*NT; i++) pad_s[i] = (i < NT) ? lvl_q[k-1][i] : 32'd0;
                for (int j = 0; j < NT; j++) lvl_d[k][j] = fp_add(pad_s[2*j], pad_s[2*j+1]);
                vld_d[k]  = vld_q[k-1];
                last_d[k] = last_q[k-1];
            end
            out_valid_d = 1'b0;
            if (vld_q[L]) begin
                if (last_q[L] || !ACC_EN) begin
                    out_data_d  = sum_s;
                    out_valid_d = 1'b1;
                    acc_d       = 32'd0;
                end else begin
                    acc_d = sum_s;
                end
            end else begin
                acc_d = acc_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline, tag and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= L; k++)
                for (int j = 0; j < NT; j++) lvl_q[k][j] <= 32'd0;
            vld_q       <= {(L+1){1'b0}};
            last_q      <= {(L+1){1'b0}};
            acc_q       <= 32'd0;
            out_data_q  <= 32'd0;
            out_valid_q <= 1'b0;
        end else begin
            lvl_q       <= lvl_d;
            vld_q       <= vld_d;
            last_q      <= last_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_dot_stencil_pipe.sv
// Scoreboard bench for dot_stencil_pipe: NT=3 accumulating and non-accumulating
// instances plus an NT=1/4/5/16 width sweep.
module tb_dot_stencil_pipe;
    localparam logic [95:0] A_D = {3{32'h3F800000}};
    localparam logic [95:0] B_D = {32'hC0A00000, 32'hBF800000, 32'h40400000};
    localparam logic [95:0] B_W = {32'hC0000000, 32'h40800000, 32'h40000000};
    localparam logic [31:0] F3  = 32'h40400000;
    localparam logic [31:0] F12 = 32'h41400000;
    localparam logic [31:0] F15 = 32'h41700000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_last = 1'b0, acc_out_ready = 1'b1, sw_valid = 1'b0;
    logic [95:0] in_data = '0, in_weight = '0;
    logic        acc_in_ready, acc_out_valid, dot_in_ready, dot_out_valid, dot_in_valid;
    logic [31:0] acc_out_data, dot_out_data, e_acc, e_dot;
    logic        sw_ir [4];
    logic        sw_ov [4];
    logic [31:0] sw_od [4];
    logic [31:0] q_acc [$];
    logic [31:0] q_dot [$];
    int          n_checks = 0, n_pass = 0;

    assign dot_in_valid = in_valid & acc_in_ready;

    always #5 clock = ~clock;

    dot_stencil_pipe #(.NT(3), .BW(32), .ACC_EN(1'b1)) u_acc (
        .clock(clock), .reset(reset), .io_in_valid(in_valid), .io_in_ready(acc_in_ready),
        .io_in_data(in_data), .io_in_weight(in_weight), .io_in_last(in_last),
        .io_out_valid(acc_out_valid), .io_out_ready(acc_out_ready), .io_out_data(acc_out_data));

    dot_stencil_pipe #(.NT(3), .BW(32), .ACC_EN(1'b0)) u_dot (
        .clock(clock), .reset(reset), .io_in_valid(dot_in_valid), .io_in_ready(dot_in_ready),
        .io_in_data(in_data), .io_in_weight(in_weight), .io_in_last(in_last),
        .io_out_valid(dot_out_valid), .io_out_ready(1'b1), .io_out_data(dot_out_data));

    dot_stencil_pipe #(.NT(1), .BW(32), .ACC_EN(1'b0)) u_sw1 (
        .clock(clock), .reset(reset), .io_in_valid(sw_valid), .io_in_ready(sw_ir[0]),
        .io_in_data({1{32'h3F800000}}), .io_in_weight({1{32'h3F800000}}), .io_in_last(1'b0),
        .io_out_valid(sw_ov[0]), .io_out_ready(1'b1), .io_out_data(sw_od[0]));

    dot_stencil_pipe #(.NT(4), .BW(32), .ACC_EN(1'b0)) u_sw4 (
        .clock(clock), .reset(reset), .io_in_valid(sw_valid), .io_in_ready(sw_ir[1]),
        .io_in_data({4{32'h3F800000}}), .io_in_weight({4{32'h3F800000}}), .io_in_last(1'b0),
        .io_out_valid(sw_ov[1]), .io_out_ready(1'b1), .io_out_data(sw_od[1]));

    dot_stencil_pipe #(.NT(5), .BW(32), .ACC_EN(1'b0)) u_sw5 (
        .clock(clock), .reset(reset), .io_in_valid(sw_valid), .io_in_ready(sw_ir[2]),
        .io_in_data({5{32'h3F800000}}), .io_in_weight({5{32'h3F800000}}), .io_in_last(1'b0),
        .io_out_valid(sw_ov[2]), .io_out_ready(1'b1), .io_out_data(sw_od[2]));

    dot_stencil_pipe #(.NT(16), .BW(32), .ACC_EN(1'b0)) u_sw16 (
        .clock(clock), .reset(reset), .io_in_valid(sw_valid), .io_in_ready(sw_ir[3]),
        .io_in_data({16{32'h3F800000}}), .io_in_weight({16{32'h3F800000}}), .io_in_last(1'b0),
        .io_out_valid(sw_ov[3]), .io_out_ready(1'b1), .io_out_data(sw_od[3]));

    // Output monitor: pops the scoreboards on every completed output handshake.
    always @(negedge clock) begin
        #2;
        if (!reset) begin
            if (acc_out_valid && acc_out_ready) begin
                n_checks++;
                if (q_acc.size() == 0) begin
                    $display("FAIL acc_unexpected: got %h with nothing expected", acc_out_data);
                end else begin
                    e_acc = q_acc.pop_front();
                    if (acc_out_data !== e_acc) $display("FAIL acc_data: got %h expected %h", acc_out_data, e_acc);
                    else n_pass++;
                end
            end
            if (dot_out_valid) begin
                n_checks++;
                if (q_dot.size() == 0) begin
                    $display("FAIL dot_unexpected: got %h with nothing expected", dot_out_data);
                end else begin
                    e_dot = q_dot.pop_front();
                    if (dot_out_data !== e_dot) $display("FAIL dot_data: got %h expected %h", dot_out_data, e_dot);
                    else n_pass++;
                end
            end
        end
    end

    task automatic send(input logic [95:0] d, input logic [95:0] w, input logic last,
                        input logic [31:0] exp_dot, input logic push_acc, input logic [31:0] exp_acc);
        int waited = 0;
        @(negedge clock);
        #1;
        in_data = d; in_weight = w; in_last = last; in_valid = 1'b1;
        while (!acc_in_ready && waited < 50) begin
            @(negedge clock);
            #1;
            waited++;
        end
        if (waited >= 50) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready stuck at %b, required 1", acc_in_ready);
        end else begin
            q_dot.push_back(exp_dot);
            if (push_acc) q_acc.push_back(exp_acc);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int waited = 0;
        while ((q_acc.size() != 0 || q_dot.size() != 0) && waited < 60) begin
            @(posedge clock);
            waited++;
        end
        repeat (6) @(posedge clock);
        n_checks++;
        if (q_acc.size() != 0 || q_dot.size() != 0)
            $display("FAIL %s_drain: pending acc=%0d dot=%0d, required 0/0", name, q_acc.size(), q_dot.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        int extra = 0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({acc_out_valid, acc_out_data, acc_in_ready} !== {1'b0, 32'd0, 1'b1})
            $display("FAIL reset_acc: got v=%b d=%h r=%b, required 0/0/1", acc_out_valid, acc_out_data, acc_in_ready);
        else n_pass++;
        n_checks++;
        if ({dot_out_valid, dot_out_data, dot_in_ready} !== {1'b0, 32'd0, 1'b1})
            $display("FAIL reset_dot: got v=%b d=%h r=%b, required 0/0/1", dot_out_valid, dot_out_data, dot_in_ready);
        else n_pass++;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock);
            #1;
            if (acc_out_valid || dot_out_valid || sw_ov[0] || sw_ov[3]) extra++;
        end
        n_checks++;
        if (extra !== 0) $display("FAIL idle_output: got %0d valid cycles, required 0", extra);
        else n_pass++;
    endtask

    task automatic test_single();
        int lat = 0;
        send(A_D, A_D, 1'b1, F3, 1'b1, F3);
        while (!dot_out_valid && lat < 10) begin
            @(posedge clock);
            #1;
            lat++;
        end
        n_checks++;
        if (lat !== 3) $display("FAIL single_latency: got %0d cycles, required 3", lat);
        else n_pass++;
        drain("single");
    endtask

    task automatic test_back_to_back();
        send(A_D, A_D, 1'b1, F3, 1'b1, F3);
        send(B_D, B_W, 1'b1, F12, 1'b1, F12);
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({dot_out_valid, dot_out_data} !== {1'b1, F3})
            $display("FAIL b2b_first: got v=%b d=%h, required 1/%h", dot_out_valid, dot_out_data, F3);
        else n_pass++;
        @(posedge clock);
        #1;
        n_checks++;
        if ({dot_out_valid, dot_out_data} !== {1'b1, F12})
            $display("FAIL b2b_second: got v=%b d=%h, required 1/%h", dot_out_valid, dot_out_data, F12);
        else n_pass++;
        drain("b2b");
    endtask

    task automatic test_accum();
        int outs = 0;
        fork
            begin
                send(A_D, A_D, 1'b0, F3, 1'b0, 32'd0);
                send(B_D, B_W, 1'b1, F12, 1'b1, F15);
                send(B_D, B_W, 1'b1, F12, 1'b1, F12);
            end
            for (int c = 0; c < 14; c++) begin
                @(posedge clock);
                #1;
                if (acc_out_valid) outs++;
            end
        join
        n_checks++;
        if (outs !== 2) $display("FAIL accum_count: got %0d results, required 2", outs);
        else n_pass++;
        drain("accum");
    endtask

    task automatic test_backpressure();
        @(negedge clock);
        acc_out_ready = 1'b0;
        fork
            begin
                send(A_D, A_D, 1'b1, F3, 1'b1, F3);
                send(B_D, B_W, 1'b1, F12, 1'b1, F12);
                send(A_D, A_D, 1'b0, F3, 1'b0, 32'd0);
                send(B_D, B_W, 1'b1, F12, 1'b1, F15);
            end
            begin
                int waited = 0;
                int bad = 0;
                logic [31:0] held;
                while (!acc_out_valid && waited < 20) begin
                    @(negedge clock);
                    #1;
                    waited++;
                end
                held = acc_out_data;
                n_checks++;
                if (held !== F3) $display("FAIL bp_held: got %h, required %h", held, F3);
                else n_pass++;
                for (int c = 0; c < 4; c++) begin
                    @(negedge clock);
                    #1;
                    if (acc_in_ready !== 1'b0 || acc_out_valid !== 1'b1 || acc_out_data !== held) bad++;
                end
                n_checks++;
                if (bad !== 0) $display("FAIL bp_stall: got %0d unstable cycles, required 0", bad);
                else n_pass++;
                @(negedge clock);
                acc_out_ready = 1'b1;
            end
        join
        drain("bp");
    endtask

    task automatic test_reset_mid();
        send(A_D, A_D, 1'b0, F3, 1'b0, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        q_acc.delete();
        q_dot.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        send(B_D, B_W, 1'b1, F12, 1'b1, F12);
        drain("reset_mid");
    endtask

    task automatic test_sweep();
        int          lat [4] = '{0, 0, 0, 0};
        logic [31:0] dat [4];
        int          exp_lat [4] = '{1, 3, 4, 5};
        logic [31:0] exp_dat [4] = '{32'h3F800000, 32'h40800000, 32'h40A00000, 32'h41800000};
        @(negedge clock);
        sw_valid = 1'b1;
        @(posedge clock);
        #1;
        sw_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clock);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (sw_ov[i] && lat[i] == 0) begin
                    lat[i] = c;
                    dat[i] = sw_od[i];
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (lat[i] !== exp_lat[i]) $display("FAIL sweep_latency[%0d]: got %0d, required %0d", i, lat[i], exp_lat[i]);
            else n_pass++;
            n_checks++;
            if (dat[i] !== exp_dat[i]) $display("FAIL sweep_data[%0d]: got %h, required %h", i, dat[i], exp_dat[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_accum();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
        $fatal(1);
    end
endmodule

// File: doc/dot_stencil_pipe.md
# dot_stencil_pipe

Pipelined, parametrised FP32 dot-product engine for the stencil datapath: the next generation of the fixed 3-tap dot unit. It multiplies NT data lanes by NT weight lanes, reduces them through a registered adder tree, and can accumulate several input beats into one stencil result (e.g. a 3x3 stencil fed as three 3-tap beats). A valid/ready handshake with output back-pressure lets it sit between the line-buffer front end and the result writer.

## Interface
- NT, 3: taps (lanes) per beat, 1..16
- BW, 32: lane width; fixed to IEEE-754 single, must be 32
- ACC_EN, 1: 1 = accumulate beats until io_in_last; 0 = every beat is a complete result
- L (derived): ceil(log2(NT)); 0 when NT=1
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- io_in_valid  in  1  beat present
- io_in_ready  out  1  beat accepted this cycle when high with io_in_valid
- io_in_data  in  BW*NT  data lanes, lane i at [BW*i+BW-1 : BW*i]
- io_in_weight  in  BW*NT  weight lanes, same packing
- io_in_last  in  1  final beat of a group (ignored when ACC_EN=0)
- io_out_valid  out  1  result held on io_out_data
- io_out_ready  in  1  downstream accepts result
- io_out_data  out  BW  FP32 dot product / group sum

## Operation
- Arithmetic: the codebase's combinational FP32 multiplier and adder units; round-to-nearest-even, denormals as those units define; no internal widening.
- Stage P (1 register): NT products p[i] = data[i]*weight[i].
- Stages T1..TL: binary adder tree, one register per level; odd operand counts padded with +0.0. Pairing is fixed: level k adds elements (2j, 2j+1) of level k-1.
- Stage A: accumulator register acc (reset +0.0).
  - Tree result s with tag last=0 (ACC_EN=1): acc <= acc + s; no output.
  - Tag last=1, or ACC_EN=0: io_out_data <= acc + s; io_out_valid <= 1; acc <= +0.0.
- valid and last tags travel in a shift register alongside the data; bubbles (valid=0) never touch acc or the output.
- Stall: stall = io_out_valid & ~io_out_ready. While stall, every stage, tag and acc holds; io_in_ready = ~stall (combinational).
- io_out_valid clears on the edge where io_out_ready=1, unless a new result loads on the same edge (then it stays 1 with the new data).
- Groups of any beat count >=1 are legal; a one-beat group is a plain dot product.

## Timing
- Reset (async, any cycle): all tag valids 0, acc = 0, io_out_valid = 0, io_out_data = 0; io_in_ready = 1 once reset deasserts. Reset mid-group discards the partial sum; the next accepted beat starts a fresh group.
- Latency: beat accepted at edge E; with no stall, io_out_valid is high after edge E+L+1 (NT=3: 3 cycles; NT=1: 1 cycle). Each stall cycle adds one cycle.
- Throughput: one beat per cycle when io_out_ready stays high; back-to-back groups need no gap.
- A stalled result is held stable (data and valid) until accepted; no beat is lost or duplicated.
- Inputs are sampled only on accept edges; lanes may change freely otherwise.

## Test plan
- Reset/idle: hold reset 3 cycles, release -> io_out_valid=0, io_out_data=0, io_in_ready=1; no output without io_in_valid.
- Single dot, NT=3, ACC_EN=0: data=weight=0x3F800000 x3 -> 0x40400000 (3.0) exactly 3 cycles after accept; next-cycle beat data {0x40400000,0xBF800000,0xC0A00000}, weight {0x40000000,0x40800000,0xC0000000} -> 0x41400000 (12.0) one cycle later.
- Accumulation, ACC_EN=1: the two beats above with last=0 then last=1 -> one output 0x41700000 (15.0); no output for the first beat; the next group starts from 0.
- Back-pressure: io_out_ready=0 for 4 cycles while streaming -> io_in_ready=0 while the result is pending, io_out_data stable, then all results delivered in order with none lost.
- Reset mid-group: accept a last=0 beat (3.0), pulse reset, send 12.0 beat with last=1 -> output 0x41400000, not 15.0.
- Width sweep: NT=1, 4, 5, 16 with all lanes 1.0 x 1.0 -> results NT as FP32 (0x3F800000, 0x40800000, 0x40A00000, 0x41800000) at latency L+1 (1, 3, 4, 5).
